// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are valid, issues lowest index first.
// Latency: a ready op dispatched at edge k issues at edge k+1; a CDB wakeup at edge k allows issue at edge k+1.
// Backpressure: full is combinational from current state; dispatch while full is dropped, so the decoder must stall.
module alu_rs #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              dispEn,
  input  logic [OP_W-1:0]   dispOp,
  input  logic [DATA_W-1:0] dispDataO,
  input  logic [DATA_W-1:0] dispDataT,
  input  logic [TAG_W-1:0]  dispTagO,
  input  logic [TAG_W-1:0]  dispTagT,
  input  logic [TAG_W-1:0]  dispWrtTag,
  input  logic [TAG_W-1:0]  CDBTag,
  input  logic [DATA_W-1:0] CDBData,
  output logic              full,
  output logic              aluEn,
  output logic [OP_W-1:0]   aluOp,
  output logic [DATA_W-1:0] aluDataO,
  output logic [DATA_W-1:0] aluDataT,
  output logic [TAG_W-1:0]  aluWrtTag
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] valid;
  logic [OP_W-1:0]    op      [ENTRIES];
  logic [DATA_W-1:0]  data_o  [ENTRIES];
  logic [DATA_W-1:0]  data_t  [ENTRIES];
  logic [TAG_W-1:0]   tag_o   [ENTRIES];
  logic [TAG_W-1:0]   tag_t   [ENTRIES];
  logic [TAG_W-1:0]   wrt_tag [ENTRIES];

  logic [ENTRIES-1:0] ready;
  logic               iss_vld;
  logic [IDX_W-1:0]   iss_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               disp_go;
  logic               cdb_vld;
  logic               byp_o;
  logic               byp_t;

  assign full    = &valid;
  assign disp_go = dispEn && !full;
  assign cdb_vld = (CDBTag != '0);
  // A producer finishing on the CDB in the dispatch cycle would otherwise be missed forever
  assign byp_o   = cdb_vld && (dispTagO == CDBTag);
  assign byp_t   = cdb_vld && (dispTagT == CDBTag);

  // Ready and priority selection work on the registered state only
  always_comb begin
    iss_vld  = 1'b0;
    iss_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ready[i] = valid[i] && (tag_o[i] == '0) && (tag_t[i] == '0);
    end
    // Scan high to low so the lowest matching index wins
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready[i]) begin
        iss_vld = 1'b1;
        iss_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // Entry storage: wakeup, issue invalidation and dispatch; issue and dispatch never hit the same entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (valid[i] && cdb_vld) begin
          if (tag_o[i] == CDBTag) begin
            data_o[i] <= CDBData;
            tag_o[i]  <= '0;
          end
          if (tag_t[i] == CDBTag) begin
            data_t[i] <= CDBData;
            tag_t[i]  <= '0;
          end
        end
      end
      if (iss_vld) begin
        valid[iss_idx] <= 1'b0;
      end
      if (disp_go) begin
        valid[free_idx]   <= 1'b1;
        op[free_idx]      <= dispOp;
        wrt_tag[free_idx] <= dispWrtTag;
        data_o[free_idx]  <= byp_o ? CDBData : dispDataO;
        tag_o[free_idx]   <= byp_o ? '0 : dispTagO;
        data_t[free_idx]  <= byp_t ? CDBData : dispDataT;
        tag_t[free_idx]   <= byp_t ? '0 : dispTagT;
      end
    end
  end

  // Issue register: fields hold their last value when nothing issues
  always_ff @(posedge clk) begin
    if (!rst) begin
      aluEn     <= 1'b0;
      aluOp     <= '0;
      aluDataO  <= '0;
      aluDataT  <= '0;
      aluWrtTag <= '0;
    end else if (clear) begin
      aluEn <= 1'b0;
    end else begin
      aluEn <= iss_vld;
      if (iss_vld) begin
        aluOp     <= op[iss_idx];
        aluDataO  <= data_o[iss_idx];
        aluDataT  <= data_t[iss_idx];
        aluWrtTag <= wrt_tag[iss_idx];
      end
    end
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, number of reservation-station entries (power of 2).
REQ-002 SHALL have parameter TAG_W, default 5, ROB tag width; tag value 0 means "no tag / operand valid".
REQ-003 SHALL have parameter DATA_W, default 32, operand and data width.
REQ-004 SHALL have parameter OP_W, default 5, ALU opcode width; opcode 0 is NOP.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-low reset; rst=0 at a rising edge resets the block.
REQ-007 SHALL have port clear  input  1  flush (branch mispredict); discards all entries.
REQ-008 SHALL have port dispEn  input  1  decoder dispatches one instruction this cycle.
REQ-009 SHALL have port dispOp  input  OP_W  opcode of dispatched instruction.
REQ-010 SHALL have port dispDataO / dispDataT  input  DATA_W  operand values (meaningful when matching tag is 0).
REQ-011 SHALL have port dispTagO / dispTagT  input  TAG_W  producer tags of operands; 0 = value already valid.
REQ-012 SHALL have port dispWrtTag  input  TAG_W  ROB destination tag.
REQ-013 SHALL have port CDBTag  input  TAG_W  broadcast tag; 0 = no broadcast.
REQ-014 SHALL have port CDBData  input  DATA_W  broadcast value.
REQ-015 SHALL have port full  output  1  combinational; 1 when all ENTRIES valid.
REQ-016 SHALL have port aluEn  output  1  registered; issued instruction valid.
REQ-017 SHALL have ports aluOp (OP_W), aluDataO (DATA_W), aluDataT (DATA_W), aluWrtTag (TAG_W)  output  registered issued instruction fields.

Function
REQ-018 Each entry SHALL hold: valid, op, dataO, tagO, dataT, tagT, wrtTag.
REQ-019 Entry ready SHALL be valid && tagO==0 && tagT==0, evaluated on registered state at start of cycle.
REQ-020 Dispatch: if dispEn && !full && !clear, the lowest-index invalid entry SHALL be written at the edge with valid=1.
REQ-021 dispEn while full SHALL be ignored (no entry changed, no error state); decoder is responsible for stalling.
REQ-022 Wakeup: at each edge with CDBTag!=0, every valid entry with tagO==CDBTag SHALL load dataO=CDBData, tagO=0; same for T.
REQ-023 Dispatch bypass: if dispTagO==CDBTag!=0 in the dispatch cycle, the new entry SHALL store CDBData with tagO=0; same for T.
REQ-024 Issue: each edge, the lowest-index ready entry SHALL be copied to alu* outputs, aluEn=1, and the entry invalidated; if none ready, aluEn=0 and alu* fields hold last values.
REQ-025 Latency: instruction dispatched with both tags 0 at edge k SHALL appear with aluEn=1 after edge k+1 at earliest; operand woken at edge k SHALL permit issue at edge k+1.
REQ-026 At most one dispatch and one issue per cycle; allocation SHALL use pre-edge valid bits, so the entry freed by issue in the same cycle is not reused until the next cycle.
REQ-027 full SHALL reflect pre-edge state; simultaneous issue does not deassert it in the same cycle.
REQ-028 clear=1 at an edge SHALL invalidate all entries and force aluEn=0; dispatch and issue in that cycle SHALL be suppressed; clear has priority over dispatch, wakeup, issue.
REQ-029 Entries SHALL NOT reorder; selection priority is strictly by index (no age tracking).

Reset
REQ-030 rst=0 at an edge SHALL clear all valid bits and set aluEn=0, aluOp=0, aluDataO=0, aluDataT=0, aluWrtTag=0; full=0 after reset.
REQ-031 rst SHALL take priority over clear, dispatch, wakeup and issue; reset mid-operation discards all pending entries.

Verification
REQ-032 Dispatch op=ADD, tags 0, dataO=5, dataT=7, wrtTag=3 at edge k -> after edge k+1: aluEn=1, aluOp=ADD, aluDataO=5, aluDataT=7, aluWrtTag=3; after k+2 aluEn=0.
REQ-033 Dispatch tagO=4; idle 3 cycles -> aluEn stays 0; CDBTag=4, CDBData=0x1234 at edge m -> issue after edge m+1 with aluDataO=0x1234.
REQ-034 Dispatch tagT=6 in same cycle as CDBTag=6, CDBData=9 -> entry captured ready, issues next edge with aluDataT=9.
REQ-035 Fill 8 entries all waiting on tag 2 -> full=1; 9th dispEn ignored; CDBTag=2 -> entries issue one per cycle in index order 0..7, full drops after first issue edge.
REQ-036 4 valid entries, assert clear for one edge -> all invalid, aluEn=0, full=0; new dispatch next cycle goes to entry 0.
REQ-037 rst=0 for one edge while 3 entries pending and aluEn=1 -> all outputs 0, no later issue of the discarded entries.
